// File: rtl/fphub_add_scheduler_pkg.sv
// Shared FPHUB types and helpers: operand special-case classification and
// the bypass sum for pairs that never need the adder core.
package fphub_pkg;

  typedef logic [63:0] fp_raw_t;

  typedef enum logic [$clog2(7)-1:0] {
    NONE   = 3'd0,
    INF_P  = 3'd1,
    INF_N  = 3'd2,
    ZERO_P = 3'd3,
    ZERO_N = 3'd4,
    ONE_P  = 3'd5,
    ONE_N  = 3'd6
  } special_e;

  function automatic fp_raw_t field_mask(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

  // Encodings for the configured format; the sign sits at bit e+m.
  function automatic fp_raw_t pos_inf(input int e, input int m);
    return field_mask(e + m);
  endfunction

  function automatic fp_raw_t neg_inf(input int e, input int m);
    return field_mask(e + m) | (64'd1 << (e + m));
  endfunction

  function automatic fp_raw_t pos_zero(input int e, input int m);
    return field_mask(0) & fp_raw_t'(e + m);
  endfunction

  function automatic fp_raw_t neg_zero(input int e, input int m);
    return 64'd1 << (e + m);
  endfunction

  function automatic special_e classify(input fp_raw_t v, input int e, input int m);
    fp_raw_t mant;
    fp_raw_t expo;
    logic    sign;
    mant = v & field_mask(m);
    expo = (v >> m) & field_mask(e);
    sign = |((v >> (e + m)) & 64'd1);
    if (expo == field_mask(e) && mant == field_mask(m)) return sign ? INF_N : INF_P;
    if (expo == '0 && mant == '0)                      return sign ? ZERO_N : ZERO_P;
    if (expo == (64'd1 << (e - 1)) && mant == '0)      return sign ? ONE_N : ONE_P;
    return NONE;
  endfunction

  function automatic logic is_special(input special_e c);
    return (c == INF_P) || (c == INF_N) || (c == ZERO_P) || (c == ZERO_N);
  endfunction

  // Opposite infinities have no NaN in this format, so +inf stands in for it.
  function automatic fp_raw_t special_sum(input special_e cx, input special_e cy,
                                          input fp_raw_t x, input fp_raw_t y,
                                          input int e, input int m);
    logic x_zero;
    logic y_zero;
    x_zero = (cx == ZERO_P) || (cx == ZERO_N);
    y_zero = (cy == ZERO_P) || (cy == ZERO_N);
    if ((cx == INF_P && cy == INF_N) || (cx == INF_N && cy == INF_P)) return pos_inf(e, m);
    if (cx == INF_P && cy == INF_P)                                   return pos_inf(e, m);
    if (cx == INF_N && cy == INF_N)                                   return neg_inf(e, m);
    if (cx == INF_P || cy == INF_P)                                   return pos_inf(e, m);
    if (cx == INF_N || cy == INF_N)                                   return neg_inf(e, m);
    if (cx == ZERO_P && cy == ZERO_N)                                 return pos_zero(e, m);
    if (x_zero)                                                       return y;
    if (y_zero)                                                       return x;
    return '0;
  endfunction

endpackage

// File: rtl/fphub_add_scheduler_if.sv
// Requester, core and result signals of the shared adder scheduler.
interface fphub_add_scheduler_if #(
  parameter int N = 2,
  parameter int E = 8,
  parameter int M = 23
);
  localparam int W   = E + M + 1;
  localparam int IDW = $clog2(N);

  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N-1:0][W-1:0] req_x;
  logic [N-1:0][W-1:0] req_y;
  logic                core_valid;
  logic [W-1:0]        core_x;
  logic [W-1:0]        core_y;
  logic [W-1:0]        core_result;
  logic                res_valid;
  logic                res_ready;
  logic [W-1:0]        res_data;
  logic [IDW-1:0]      res_id;
  logic                res_special;

  modport slave (
    input  req_valid, req_x, req_y, core_result, res_ready,
    output req_ready, core_valid, core_x, core_y, res_valid, res_data, res_id, res_special
  );

  modport master (
    output req_valid, req_x, req_y, core_result, res_ready,
    input  req_ready, core_valid, core_x, core_y, res_valid, res_data, res_id, res_special
  );
endinterface

// File: rtl/fphub_add_scheduler_fifo.sv
// Shift-register result FIFO; entry 0 is the registered head, so the
// outputs hold still until popped. Push while full is allowed with a pop.
module fphub_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (pop_i && cnt_q != '0) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
      mem_d[DEPTH-1] = '0;
      cnt_d = cnt_q - 1'b1;
    end
    if (push_i && cnt_d < CW'(DEPTH)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == cnt_d) mem_d[i] = data_i;
      end
      cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[0];
endmodule

// File: rtl/fphub_add_scheduler.sv
// Shares one fixed-latency FPHUB adder among N requesters: round-robin grant,
// special-case bypass, in-order tag delay line, credit-guarded result FIFO.
module fphub_add_scheduler
  import fphub_pkg::*;
#(
  parameter int M     = 23,
  parameter int E     = 8,
  parameter int N     = 2,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  fphub_add_scheduler_if.slave bus
);
  localparam int W   = E + M + 1;
  localparam int IDW = $clog2(N);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int FW  = IDW + 1 + W;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
    logic           special;
    logic [W-1:0]   data;
  } tag_t;

  logic [IDW-1:0] rr_q, rr_d;
  logic [CW-1:0]  outstanding_q, outstanding_d;
  tag_t           dl_q [LAT];
  tag_t           dl_d [LAT];

  logic           credit_ok, grant_found, accept, push, pop, sel_special;
  logic [IDW-1:0] grant_id;
  int             best_dist;
  logic [W-1:0]   sel_x, sel_y, bypass_val, push_data;
  special_e       cls_x, cls_y;
  logic           fifo_valid;
  logic [FW-1:0]  fifo_din, fifo_dout;

  // Grant never looks at pending pops, so req_ready depends only on state.
  assign credit_ok = outstanding_q < CW'(DEPTH);

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    best_dist   = N;
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] && ((i + N - int'(rr_q)) % N) < best_dist) begin
        best_dist   = (i + N - int'(rr_q)) % N;
        grant_id    = IDW'(i);
        grant_found = 1'b1;
      end
    end
  end

  assign accept = grant_found & credit_ok;

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (accept && grant_id == IDW'(i)) bus.req_ready[i] = 1'b1;
    end
  end

  assign sel_x       = bus.req_x[grant_id];
  assign sel_y       = bus.req_y[grant_id];
  assign cls_x       = classify(fp_raw_t'(sel_x), E, M);
  assign cls_y       = classify(fp_raw_t'(sel_y), E, M);
  assign sel_special = is_special(cls_x) | is_special(cls_y);
  assign bypass_val  = W'(special_sum(cls_x, cls_y, fp_raw_t'(sel_x), fp_raw_t'(sel_y), E, M));

  assign bus.core_valid = accept & ~sel_special & ~rst;
  assign bus.core_x     = sel_x;
  assign bus.core_y     = sel_y;

  // Bypass results ride the same delay as core results to keep issue order.
  always_comb begin
    dl_d[0].valid   = accept;
    dl_d[0].id      = grant_id;
    dl_d[0].special = sel_special;
    dl_d[0].data    = bypass_val;
    for (int i = 1; i < LAT; i++) dl_d[i] = dl_q[i-1];
  end

  assign push      = dl_q[LAT-1].valid;
  assign push_data = dl_q[LAT-1].special ? dl_q[LAT-1].data : bus.core_result;
  assign fifo_din  = {dl_q[LAT-1].id, dl_q[LAT-1].special, push_data};
  assign pop       = fifo_valid & bus.res_ready;

  always_comb begin
    outstanding_d = outstanding_q;
    case ({accept, pop})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
    rr_d = rr_q;
    if (accept) rr_d = (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q          <= '0;
      outstanding_q <= '0;
      for (int i = 0; i < LAT; i++) dl_q[i] <= '0;
    end else begin
      rr_q          <= rr_d;
      outstanding_q <= outstanding_d;
      dl_q          <= dl_d;
    end
  end

  fphub_result_fifo #(
    .WIDTH(FW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .data_i (fifo_din),
    .pop_i  (pop),
    .valid_o(fifo_valid),
    .data_o (fifo_dout)
  );

  assign bus.res_valid = fifo_valid;
  assign {bus.res_id, bus.res_special, bus.res_data} = fifo_dout;
endmodule
